// File: rtl/clken_gen.sv
// rtl/clken_gen.sv - fractional clock-enable generator, NUM_CH phase accumulators with lock/reprogram FSM
// Optional CLKEN_PHASE_ALIGN_EN: reprogramming clears every accumulator so all channels restart in phase.
module clken_gen #(
  parameter int NUM_CH = 3,
  parameter int ACC_W = 16,
  parameter int MOD = 50000,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INC = {16'd4000, 16'd10000, 16'd20000},
  parameter int LOCK_CYC = 64,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clken,
  output logic              locked
);

  localparam int CNT_W = $clog2(LOCK_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYC - 1);
  localparam logic [ACC_W:0]   MOD_X    = (ACC_W + 1)'(MOD);
  localparam logic [ACC_W-1:0] MOD_V    = ACC_W'(MOD);
  localparam logic [CH_W:0]    NCH_X    = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {LOCKING, RUN, UPDATE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  lock_cnt;
  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [ACC_W-1:0]  inc [NUM_CH];
  logic [ACC_W:0]    sum [NUM_CH];
  logic [ACC_W-1:0]  nxt_acc [NUM_CH];
  logic [NUM_CH-1:0] hit;
  logic [CH_W-1:0]   upd_ch;
  logic [ACC_W-1:0]  upd_inc;
  logic              cfg_bad;
  logic              accept;

  // One extra bit on the sum so acc+inc can reach 2*MOD-1 without wrapping.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]     = {1'b0, acc[i]} + {1'b0, inc[i]};
      hit[i]     = (sum[i] >= MOD_X);
      nxt_acc[i] = hit[i] ? ACC_W'(sum[i] - MOD_X) : sum[i][ACC_W-1:0];
    end
  end

  assign cfg_bad = ({1'b0, cfg_ch} >= NCH_X) || (cfg_inc > MOD_V);
  assign accept  = cfg_valid && cfg_ready;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= LOCKING;
      lock_cnt  <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      clken     <= '0;
      upd_ch    <= '0;
      upd_inc   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        inc[i] <= INIT_INC[i*ACC_W +: ACC_W];
      end
    end else begin
      cfg_err <= 1'b0;
      case (state)
        LOCKING: begin
          clken <= '0;
          if (lock_cnt == CNT_LAST) begin
            state     <= RUN;
            locked    <= 1'b1;
            cfg_ready <= 1'b1;
            lock_cnt  <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        RUN: begin
          // An accepted reprogram freezes the accumulators so no pulse is lost.
          if (accept && !cfg_bad) begin
            state     <= UPDATE;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            clken     <= '0;
            upd_ch    <= cfg_ch;
            upd_inc   <= cfg_inc;
          end else begin
            cfg_err <= accept;
            clken   <= hit;
            for (int i = 0; i < NUM_CH; i++) acc[i] <= nxt_acc[i];
          end
        end
        UPDATE: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (upd_ch == CH_W'(i)) inc[i] <= upd_inc;
`ifdef CLKEN_PHASE_ALIGN_EN
            acc[i] <= '0;
`else
            acc[i] <= acc[i];
`endif
          end
          clken    <= '0;
          state    <= LOCKING;
          lock_cnt <= '0;
        end
        default: state <= LOCKING;
      endcase
    end
  end

endmodule

// File: tb/tb_clken_gen.sv
// tb/tb_clken_gen.sv - scoreboard bench for clken_gen: lock timing, pulse rates, reject, reprogram, reset override
module tb_clken_gen;

  logic       refclk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [15:0] cfg_inc;
  logic       cfg_err;
  logic [2:0] clken;
  logic       locked;

  clken_gen dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_err(cfg_err), .clken(clken), .locked(locked)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  // kind 0: masked compare of {locked,cfg_ready,cfg_err,clken}; kind 1: pulse count on ch over (start,cyc]
  typedef struct {
    string      name;
    int         cyc;
    int         kind;
    int         start;
    int         ch;
    int         exp;
    logic [5:0] mask;
  } item_t;

  item_t q[$];
  item_t keep[$];
  logic [2:0] hist [int];
  int checks = 0;
  int failures = 0;

  localparam logic [5:0] ALL  = 6'h3f;
  localparam logic [5:0] CTRL = 6'b111000;

  task automatic push_vec(input string name, input int c, input logic [5:0] mask, input logic [5:0] val);
    item_t it;
    it.name = name; it.cyc = c; it.kind = 0; it.start = 0; it.ch = 0; it.exp = int'(val); it.mask = mask;
    q.push_back(it);
  endtask

  task automatic push_cnt(input string name, input int s, input int e, input int ch, input int n);
    item_t it;
    it.name = name; it.cyc = e; it.kind = 1; it.start = s; it.ch = ch; it.exp = n; it.mask = '0;
    q.push_back(it);
  endtask

  always @(negedge refclk) begin
    logic [5:0] obs;
    logic [5:0] want;
    int n;
    obs = {locked, cfg_ready, cfg_err, clken};
    hist[cyc] = clken;
    keep.delete();
    foreach (q[i]) begin
      if (q[i].cyc == cyc) begin
        checks++;
        if (q[i].kind == 0) begin
          want = 6'(q[i].exp);
          if ((obs & q[i].mask) !== (want & q[i].mask)) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", q[i].name, cyc, obs, want, q[i].mask);
          end
        end else begin
          n = 0;
          for (int c = q[i].start + 1; c <= q[i].cyc; c++)
            if (hist.exists(c) && hist[c][q[i].ch] === 1'b1) n++;
          if (n != q[i].exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", q[i].name, cyc, n, q[i].exp);
          end
        end
      end else if (q[i].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missed cyc=%0d now=%0d", q[i].name, q[i].cyc, cyc);
      end else begin
        keep.push_back(q[i]);
      end
    end
    q = keep;
  end

  task automatic tick_to(input int c);
    while (cyc < c) begin
      @(posedge refclk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
    $fatal(1, "watchdog");
  end

  int c0, r, u, r2, c1, c2, r3, u2, r4;

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
    c0 = 3;
    r  = c0 + 64;
    u  = r + 202;
    r2 = u + 65;
    c1 = r2 + 62;
    c2 = c1 + 31;
    r3 = c2 + 64;
    u2 = r3 + 101;
    r4 = u2 + 65;

    push_vec("reset_state", c0, ALL, 6'b000000);
    push_vec("lock_pending", r - 1, ALL, 6'b000000);
    push_vec("lock_rise", r, ALL, 6'b110000);
    push_vec("ch0_not_yet", r + 2, ALL, 6'b110000);
    push_vec("ch0_first", r + 3, ALL, 6'b110001);
    push_vec("ch01_pulse", r + 5, ALL, 6'b110011);
    push_vec("ch02_pulse", r + 13, ALL, 6'b110101);
    push_cnt("win1_ch0", r, r + 100, 0, 40);
    push_cnt("win1_ch1", r, r + 100, 1, 20);
    push_cnt("win1_ch2", r, r + 100, 2, 8);
    push_vec("err_inc_big", r + 121, CTRL, 6'b111000);
    push_vec("err_inc_clear", r + 122, CTRL, 6'b110000);
    push_vec("err_ch_big", r + 131, CTRL, 6'b111000);
    push_vec("err_ch_clear", r + 132, CTRL, 6'b110000);
    push_cnt("win2_ch0", r + 100, r + 200, 0, 40);
    push_cnt("win2_ch1", r + 100, r + 200, 1, 20);
    push_cnt("win2_ch2", r + 100, r + 200, 2, 8);
    push_vec("update_state", u, ALL, 6'b000000);
    push_vec("relock_start", u + 1, ALL, 6'b000000);
    push_vec("relock_last", u + 64, ALL, 6'b000000);
    push_vec("relock_rise", r2, ALL, 6'b110000);
    push_vec("ch1_full_rate", r2 + 1, ALL, 6'b110010);
`ifdef CLKEN_PHASE_ALIGN_EN
    push_vec("phase_ch0", r2 + 2, ALL, 6'b110010);
    push_vec("phase_ch2", r2 + 12, ALL, 6'b110010);
`else
    push_vec("phase_ch0", r2 + 2, ALL, 6'b110011);
    push_vec("phase_ch2", r2 + 12, ALL, 6'b110111);
`endif
    push_cnt("ch1_every_cycle", r2, r2 + 50, 1, 50);
    push_vec("update_before_rst", r2 + 60, ALL, 6'b000000);
    push_vec("rst_in_update", r2 + 61, ALL, 6'b000000);
    push_vec("locking_mid", c1 + 30, ALL, 6'b000000);
    push_vec("rst_in_locking", c2, ALL, 6'b000000);
    push_vec("restart_pending", r3 - 1, ALL, 6'b000000);
    push_vec("restart_rise", r3, ALL, 6'b110000);
    push_vec("init_inc_ch1", r3 + 1, ALL, 6'b110000);
    push_vec("init_inc_ch2", r3 + 13, ALL, 6'b110101);
    push_cnt("win3_ch0", r3, r3 + 100, 0, 40);
    push_cnt("win3_ch1", r3, r3 + 100, 1, 20);
    push_cnt("win3_ch2", r3, r3 + 100, 2, 8);
    push_vec("inc0_relock", r4, ALL, 6'b110000);
    push_cnt("inc0_ch0", r4, r4 + 50, 0, 0);
    push_cnt("inc0_ch1", r4, r4 + 50, 1, 10);
    push_cnt("inc0_ch2", r4, r4 + 50, 2, 4);

    tick_to(c0);
    rst = 1'b0;
    // a request while locking must be dropped
    tick_to(c0 + 10);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 16'd50000;
    tick_to(c0 + 13);
    cfg_valid = 1'b0;

    tick_to(r + 120);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'd60000;
    tick_to(r + 121);
    cfg_valid = 1'b0;
    tick_to(r + 130);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 16'd100;
    tick_to(r + 131);
    cfg_valid = 1'b0;

    tick_to(r + 201);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 16'd50000;
    tick_to(r + 202);
    cfg_valid = 1'b0;

    tick_to(r2 + 59);
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 16'd1000;
    tick_to(r2 + 60);
    cfg_valid = 1'b0;
    rst = 1'b1;
    tick_to(c1);
    rst = 1'b0;
    tick_to(c1 + 30);
    rst = 1'b1;
    tick_to(c2);
    rst = 1'b0;

    tick_to(r3 + 100);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'd0;
    tick_to(r3 + 101);
    cfg_valid = 1'b0;

    tick_to(r4 + 55);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover got=%0d pending want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
